// File: rtl/scoreboard_reg_file_pkg.sv
// Shared defaults and helpers for the scoreboarded MIPS register file.
// Optional same-cycle write bypass is selected by defining REGFILE_BYPASS_EN.
package scoreboard_reg_file_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_REG   = 0;

    // One busy bit per register, including the never-busy register 0.
    function automatic int busy_w(input int addr_w);
        return 2 ** addr_w;
    endfunction

endpackage

// File: rtl/scoreboard_reg_file_if.sv
// Read, claim and writeback port bundle of the scoreboarded register file.
// master = decode/issue + writeback side, slave = register file.
interface scoreboard_reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_reg1;
    logic [ADDR_W-1:0] rd_reg2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_reg;
    logic              issue_ready;
    logic [ADDR_W-1:0] busy_count;

    modport master (
        output wr_en, wr_reg, wr_data, rd_reg1, rd_reg2, issue_valid, issue_reg,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, issue_ready, busy_count
    );

    modport slave (
        input  wr_en, wr_reg, wr_data, rd_reg1, rd_reg2, issue_valid, issue_reg,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, issue_ready, busy_count
    );
endinterface

// File: rtl/scoreboard_reg_file_scoreboard.sv
// Pending-write scoreboard: busy vector, claim acceptance and pending count.
// A claim and a writeback to the same register in one edge leaves it busy.
module scoreboard_reg_file_scoreboard
    import scoreboard_reg_file_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_reg_i,
    input  logic              issue_valid_i,
    input  logic [ADDR_W-1:0] issue_reg_i,
    input  logic [ADDR_W-1:0] rd_reg1_i,
    input  logic [ADDR_W-1:0] rd_reg2_i,
    output logic              issue_ready_o,
    output logic              busy1_o,
    output logic              busy2_o,
    output logic [ADDR_W-1:0] busy_count_o
);
    localparam int DEPTH = busy_w(ADDR_W);
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              set_claim, clr_write, inc, dec;

    // A write releasing the same register makes it claimable this cycle.
    assign issue_ready_o = !busy_q[issue_reg_i] || (wr_en_i && (wr_reg_i == issue_reg_i));

    always_comb begin
        clr_write = wr_en_i && (wr_reg_i != ZERO_IDX);
        set_claim = issue_valid_i && issue_ready_o && (issue_reg_i != ZERO_IDX);
        inc       = set_claim && !busy_q[issue_reg_i];
        dec       = clr_write && busy_q[wr_reg_i] && !(set_claim && (issue_reg_i == wr_reg_i));
        busy_d    = busy_q;
        if (clr_write) busy_d[wr_reg_i] = 1'b0;
        if (set_claim) busy_d[issue_reg_i] = 1'b1;
        count_d   = count_q + ADDR_W'(inc) - ADDR_W'(dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy1_o      = busy_q[rd_reg1_i];
    assign busy2_o      = busy_q[rd_reg2_i];
    assign busy_count_o = count_q;

endmodule

// File: rtl/scoreboard_reg_file.sv
// Two-read/one-write register file with hardwired zero register and scoreboard.
// Define REGFILE_BYPASS_EN to forward writeback data/busy release in the same cycle.
module scoreboard_reg_file
    import scoreboard_reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input logic clk,
    input logic rst_n,
    scoreboard_reg_file_if.slave bus
);
    localparam int DEPTH = busy_w(ADDR_W);
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [ADDR_W-1:0] rd_reg  [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              raw_busy [2];
    logic              rd_busy  [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (bus.wr_en && (bus.wr_reg != ZERO_IDX)) begin
            regs_q[bus.wr_reg] <= bus.wr_data;
        end
    end

    scoreboard_reg_file_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_i      (bus.wr_en),
        .wr_reg_i     (bus.wr_reg),
        .issue_valid_i(bus.issue_valid),
        .issue_reg_i  (bus.issue_reg),
        .rd_reg1_i    (bus.rd_reg1),
        .rd_reg2_i    (bus.rd_reg2),
        .issue_ready_o(bus.issue_ready),
        .busy1_o      (raw_busy[0]),
        .busy2_o      (raw_busy[1]),
        .busy_count_o (bus.busy_count)
    );

    assign rd_reg[0] = bus.rd_reg1;
    assign rd_reg[1] = bus.rd_reg2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = (rd_reg[p] == ZERO_IDX) ? '0 : regs_q[rd_reg[p]];
            rd_busy[p] = raw_busy[p];
`ifdef REGFILE_BYPASS_EN
            // Reset gating keeps the forward path quiet while rst_n is held.
            if (rst_n && bus.wr_en && (bus.wr_reg == rd_reg[p])) begin
                rd_busy[p] = 1'b0;
                if (rd_reg[p] != ZERO_IDX) rd_data[p] = bus.wr_data;
            end
`endif
        end
    end

    assign bus.rd_data1 = rd_data[0];
    assign bus.rd_data2 = rd_data[1];
    assign bus.rd_busy1 = rd_busy[0];
    assign bus.rd_busy2 = rd_busy[1];

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Self-checking bench for scoreboard_reg_file against a register/busy-set model.
module tb_scoreboard_reg_file;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scoreboard_reg_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    scoreboard_reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [DW-1:0] m_regs [N];
    bit            m_busy [N];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic void model_clear();
        for (int i = 0; i < N; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int idx);
        if (idx == 0) return '0;
        if (BYP && bus.wr_en && int'(bus.wr_reg) == idx) return bus.wr_data;
        return m_regs[idx];
    endfunction

    function automatic bit exp_busy(input int idx);
        if (BYP && bus.wr_en && int'(bus.wr_reg) == idx) return 1'b0;
        return m_busy[idx];
    endfunction

    function automatic bit exp_ready();
        return !m_busy[int'(bus.issue_reg)] || (bus.wr_en && bus.wr_reg == bus.issue_reg);
    endfunction

    task automatic idle();
        bus.wr_en = 1'b0;
        bus.issue_valid = 1'b0;
    endtask

    // One clock edge: model commits the same edge the DUT does.
    task automatic step();
        bit wen, iv, rdy;
        int wr, ir;
        logic [DW-1:0] d;
        wen = bus.wr_en; wr = int'(bus.wr_reg); d = bus.wr_data;
        iv = bus.issue_valid; ir = int'(bus.issue_reg);
        rdy = exp_ready();
        @(posedge clk);
        if (wen && wr != 0) begin
            m_regs[wr] = d;
            m_busy[wr] = 1'b0;
        end
        if (iv && rdy && ir != 0) m_busy[ir] = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        bus.wr_en = 1'b1; bus.wr_reg = 5'd3; bus.wr_data = 32'hDEAD_BEEF;
        bus.rd_reg1 = 5'd3; bus.rd_reg2 = 5'd17;
        bus.issue_valid = 1'b0; bus.issue_reg = 5'd3;
        repeat (2) @(posedge clk);
        #2;
        n_checks++; if (bus.busy_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.busy_count); end
        n_checks++; if (bus.rd_data1 !== 32'd0) begin n_fail++; $display("FAIL reset_rd1: got %h want 0", bus.rd_data1); end
        n_checks++; if (bus.rd_busy1 !== 1'b0 || bus.rd_busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b%b want 00", bus.rd_busy1, bus.rd_busy2); end
        n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.issue_ready); end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_all();
        for (int i = 0; i < N; i++) begin
            bus.wr_en = 1'b1; bus.wr_reg = AW'(i); bus.wr_data = DW'(i * 2);
            step();
        end
        idle();
        for (int k = 0; k < N; k++) begin
            bus.rd_reg1 = AW'(k); bus.rd_reg2 = AW'(N - 1 - k);
            #1;
            n_checks++; if (bus.rd_data1 !== DW'(2 * k)) begin n_fail++; $display("FAIL write_all_rd1[%0d]: got %h want %h", k, bus.rd_data1, DW'(2 * k)); end
            n_checks++; if (bus.rd_data2 !== DW'(2 * (N - 1 - k))) begin n_fail++; $display("FAIL write_all_rd2[%0d]: got %h want %h", N - 1 - k, bus.rd_data2, DW'(2 * (N - 1 - k))); end
            n_checks++; if (bus.rd_busy1 !== 1'b0 || bus.rd_busy2 !== 1'b0) begin n_fail++; $display("FAIL write_all_busy[%0d]: got %b%b want 00", k, bus.rd_busy1, bus.rd_busy2); end
        end
        n_checks++; if (bus.busy_count !== 5'd0) begin n_fail++; $display("FAIL write_all_count: got %0d want 0", bus.busy_count); end
    endtask

    task automatic test_claim();
        bus.issue_valid = 1'b1; bus.issue_reg = 5'd5; bus.rd_reg1 = 5'd5;
        #1;
        n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL claim_ready_free: got %b want 1", bus.issue_ready); end
        n_checks++; if (bus.rd_busy1 !== 1'b0) begin n_fail++; $display("FAIL claim_before_edge: got %b want 0", bus.rd_busy1); end
        step();
        n_checks++; if (bus.rd_busy1 !== 1'b1) begin n_fail++; $display("FAIL claim_busy5: got %b want 1", bus.rd_busy1); end
        n_checks++; if (bus.busy_count !== 5'd1) begin n_fail++; $display("FAIL claim_count: got %0d want 1", bus.busy_count); end
        n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL claim_again_ready: got %b want 0", bus.issue_ready); end
        step();
        n_checks++; if (bus.busy_count !== 5'd1) begin n_fail++; $display("FAIL claim_again_count: got %0d want 1", bus.busy_count); end
        bus.issue_valid = 1'b0;
        bus.wr_en = 1'b1; bus.wr_reg = 5'd5; bus.wr_data = 32'hAB;
        step();
        idle();
        #1;
        n_checks++; if (bus.rd_busy1 !== 1'b0) begin n_fail++; $display("FAIL release_busy5: got %b want 0", bus.rd_busy1); end
        n_checks++; if (bus.busy_count !== 5'd0) begin n_fail++; $display("FAIL release_count: got %0d want 0", bus.busy_count); end
        n_checks++; if (bus.rd_data1 !== 32'hAB) begin n_fail++; $display("FAIL release_data5: got %h want 000000ab", bus.rd_data1); end
    endtask

    task automatic test_claim_write_same();
        bus.issue_valid = 1'b1; bus.issue_reg = 5'd7;
        step();
        bus.wr_en = 1'b1; bus.wr_reg = 5'd7; bus.wr_data = 32'h11;
        #1;
        n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL same_ready: got %b want 1", bus.issue_ready); end
        step();
        idle();
        bus.rd_reg1 = 5'd7;
        #1;
        n_checks++; if (bus.rd_data1 !== 32'h11) begin n_fail++; $display("FAIL same_data7: got %h want 00000011", bus.rd_data1); end
        n_checks++; if (bus.rd_busy1 !== 1'b1) begin n_fail++; $display("FAIL same_busy7: got %b want 1", bus.rd_busy1); end
        n_checks++; if (bus.busy_count !== 5'd1) begin n_fail++; $display("FAIL same_count: got %0d want 1", bus.busy_count); end
    endtask

    task automatic test_bypass();
        bus.issue_valid = 1'b1; bus.issue_reg = 5'd9;
        step();
        idle();
        bus.wr_en = 1'b1; bus.wr_reg = 5'd9; bus.wr_data = 32'h55; bus.rd_reg2 = 5'd9;
        #1;
        n_checks++; if (bus.rd_data2 !== (BYP ? 32'h55 : 32'd18)) begin n_fail++; $display("FAIL bypass_data: got %h want %h", bus.rd_data2, (BYP ? 32'h55 : 32'd18)); end
        n_checks++; if (bus.rd_busy2 !== !BYP) begin n_fail++; $display("FAIL bypass_busy: got %b want %b", bus.rd_busy2, !BYP); end
        step();
        idle();
        #1;
        n_checks++; if (bus.rd_data2 !== 32'h55) begin n_fail++; $display("FAIL bypass_after: got %h want 00000055", bus.rd_data2); end
        n_checks++; if (bus.rd_busy2 !== 1'b0) begin n_fail++; $display("FAIL bypass_busy_after: got %b want 0", bus.rd_busy2); end
    endtask

    task automatic test_back_to_back();
        bus.issue_valid = 1'b1;
        for (int r = 1; r < N; r++) begin
            bus.issue_reg = AW'(r);
            #1;
            n_checks++; if (bus.issue_ready !== exp_ready()) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want %b", r, bus.issue_ready, exp_ready()); end
            step();
        end
        idle();
        #1;
        n_checks++; if (bus.busy_count !== 5'd31) begin n_fail++; $display("FAIL b2b_count: got %0d want 31", bus.busy_count); end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_clear();
        bus.rd_reg1 = 5'd9;
        #1;
        n_checks++; if (bus.busy_count !== 5'd0) begin n_fail++; $display("FAIL async_count: got %0d want 0", bus.busy_count); end
        n_checks++; if (bus.rd_data1 !== 32'd0) begin n_fail++; $display("FAIL async_rd9: got %h want 0", bus.rd_data1); end
        for (int k = 0; k < N; k++) begin
            bus.rd_reg1 = AW'(k); bus.rd_reg2 = AW'(k);
            #1;
            n_checks++; if (bus.rd_data1 !== 32'd0 || bus.rd_busy2 !== 1'b0) begin n_fail++; $display("FAIL async_reg[%0d]: got %h/%b want 0/0", k, bus.rd_data1, bus.rd_busy2); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_reg();
        bus.issue_valid = 1'b1; bus.issue_reg = 5'd0;
        #1;
        n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b want 1", bus.issue_ready); end
        step();
        n_checks++; if (bus.busy_count !== 5'd0) begin n_fail++; $display("FAIL zero_count: got %0d want 0", bus.busy_count); end
        idle();
        bus.wr_en = 1'b1; bus.wr_reg = 5'd0; bus.wr_data = 32'hFF; bus.rd_reg1 = 5'd0;
        #1;
        n_checks++; if (bus.rd_data1 !== 32'd0) begin n_fail++; $display("FAIL zero_bypass: got %h want 0", bus.rd_data1); end
        step();
        idle();
        #1;
        n_checks++; if (bus.rd_data1 !== 32'd0 || bus.rd_busy1 !== 1'b0) begin n_fail++; $display("FAIL zero_read: got %h/%b want 0/0", bus.rd_data1, bus.rd_busy1); end
    endtask

    task automatic test_random();
        int r1, r2;
        for (int c = 0; c < 400; c++) begin
            bus.wr_en       = ($urandom_range(0, 2) == 0);
            bus.wr_reg      = AW'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 31));
            bus.wr_data     = $urandom;
            bus.issue_valid = ($urandom_range(0, 1) != 0);
            bus.issue_reg   = AW'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 31));
            r1 = $urandom_range(0, 1) != 0 ? int'(bus.wr_reg) : int'($urandom_range(0, 31));
            r2 = int'($urandom_range(0, 31));
            bus.rd_reg1 = AW'(r1); bus.rd_reg2 = AW'(r2);
            #1;
            n_checks++; if (bus.rd_data1 !== exp_rd(r1)) begin n_fail++; $display("FAIL rand_rd1 c%0d r%0d: got %h want %h", c, r1, bus.rd_data1, exp_rd(r1)); end
            n_checks++; if (bus.rd_data2 !== exp_rd(r2)) begin n_fail++; $display("FAIL rand_rd2 c%0d r%0d: got %h want %h", c, r2, bus.rd_data2, exp_rd(r2)); end
            n_checks++; if (bus.rd_busy1 !== exp_busy(r1) || bus.rd_busy2 !== exp_busy(r2)) begin n_fail++; $display("FAIL rand_busy c%0d: got %b%b want %b%b", c, bus.rd_busy1, bus.rd_busy2, exp_busy(r1), exp_busy(r2)); end
            n_checks++; if (bus.issue_ready !== exp_ready()) begin n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", c, bus.issue_ready, exp_ready()); end
            n_checks++; if (int'(bus.busy_count) !== m_count()) begin n_fail++; $display("FAIL rand_count c%0d: got %0d want %0d", c, bus.busy_count, m_count()); end
            step();
        end
        idle();
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_reg = '0; bus.wr_data = '0;
        bus.rd_reg1 = '0; bus.rd_reg2 = '0;
        bus.issue_valid = 1'b0; bus.issue_reg = '0;
        test_reset();
        test_write_all();
        test_claim();
        test_claim_write_same();
        test_bypass();
        test_back_to_back();
        test_zero_reg();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
